// File: rtl/move_queue_builder.sv
// move_queue_builder: accepts 4-bit cube moves from the move producer and
// buffers them in a show-ahead FIFO that the decoder drains one entry per
// pop handshake.
//
// Build option MQ_MERGE_EN:
//   defined   - consecutive same-face turns are merged/cancelled through a
//               one-entry tail register before reaching the FIFO.
//   undefined - pass-through: every valid move is written straight to the FIFO.
//
// Move code: [3:1]=face 0..5 (W,G,R,B,O,Y), [0]=dir (0=CW, 1=CCW),
//            4'hF=end-of-sequence, 4'hC..4'hE invalid (dropped).
//
// Ports:
//   i_clk_12m    system clock
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous clear, same effect as reset
//   i_move_valid producer has a move on i_move
//   i_move       move code
//   o_move_ready block can accept (transfer on valid && ready)
//   o_q_valid    FIFO non-empty, o_q_move valid
//   o_q_move     FIFO head (show-ahead)
//   i_q_pop      consumer takes the head; ignored when empty
//   o_count      FIFO occupancy 0..DEPTH
//   o_seq_done   end marker received and tail flushed
//   o_overflow   sticky: write attempted while FIFO full
module move_queue_builder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          i_clk_12m,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_move_valid,
  input  logic [3:0]    i_move,
  output logic          o_move_ready,
  output logic          o_q_valid,
  output logic [3:0]    o_q_move,
  input  logic          i_q_pop,
  output logic [AW:0]   o_count,
  output logic          o_seq_done,
  output logic          o_overflow
);

  localparam logic [3:0]  END_CODE   = 4'hF;
  localparam logic [3:0]  FIRST_BAD  = 4'hC;
  localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ALMOST = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_HOLD   = 2'd1,
    S_FLUSH2 = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, ready_d;
  logic          seq_done_q;
  logic          overflow_q, overflow_d;
  logic [3:0]    mem_q [DEPTH];

  logic          xfer;
  logic          is_end;
  logic          is_move;
  logic          wr_req;
  logic [3:0]    wr_data;
  logic          wr_ok;
  logic          rd_ok;

  assign xfer    = i_move_valid & ready_q;
  assign is_end  = (i_move == END_CODE);
  assign is_move = (i_move < FIRST_BAD);

`ifdef MQ_MERGE_EN
  // Tail holds the pending face and its net quarter-turns mod 4.
  logic [2:0] tail_face_q, tail_face_d;
  logic [1:0] tail_qt_q, tail_qt_d;
  // Face owed a second CW entry while in S_FLUSH2 (the tail already moved on).
  logic [2:0] f2_face_q, f2_face_d;
  logic       end_pend_q, end_pend_d;
  logic [1:0] qt_add;
  logic [1:0] qt_sum;

  assign qt_add = i_move[0] ? 2'd3 : 2'd1;
  assign qt_sum = tail_qt_q + qt_add;

  // Next-state, tail update and FIFO write request.
  always_comb begin
    state_d     = state_q;
    tail_face_d = tail_face_q;
    tail_qt_d   = tail_qt_q;
    f2_face_d   = f2_face_q;
    end_pend_d  = end_pend_q;
    wr_req      = 1'b0;
    wr_data     = 4'h0;
    case (state_q)
      S_EMPTY: begin
        if (xfer) begin
          if (is_end) begin
            state_d = S_DONE;
          end else if (is_move) begin
            tail_face_d = i_move[3:1];
            tail_qt_d   = qt_add;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (xfer) begin
          if (is_move && (i_move[3:1] == tail_face_q)) begin
            tail_qt_d = qt_sum;
            if (qt_sum == 2'd0) begin
              state_d = S_EMPTY;
            end
          end else if (is_move || is_end) begin
            // Flush the tail; a half turn needs two CW entries.
            wr_req  = 1'b1;
            wr_data = {tail_face_q, (tail_qt_q == 2'd3)};
            if (is_move) begin
              tail_face_d = i_move[3:1];
              tail_qt_d   = qt_add;
            end
            if (tail_qt_q == 2'd2) begin
              f2_face_d  = tail_face_q;
              end_pend_d = is_end;
              state_d    = S_FLUSH2;
            end else if (is_end) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_FLUSH2: begin
        wr_req  = 1'b1;
        wr_data = {f2_face_q, 1'b0};
        state_d = end_pend_q ? S_DONE : S_HOLD;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // Tail registers.
  always_ff @(posedge i_clk_12m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tail_face_q <= 3'd0;
      tail_qt_q   <= 2'd0;
      f2_face_q   <= 3'd0;
      end_pend_q  <= 1'b0;
    end else if (i_clear) begin
      tail_face_q <= 3'd0;
      tail_qt_q   <= 2'd0;
      f2_face_q   <= 3'd0;
      end_pend_q  <= 1'b0;
    end else begin
      tail_face_q <= tail_face_d;
      tail_qt_q   <= tail_qt_d;
      f2_face_q   <= f2_face_d;
      end_pend_q  <= end_pend_d;
    end
  end

  // Stall before the last free slot so a two-entry flush always fits.
  assign ready_d = (state_d != S_FLUSH2) && (count_d < CNT_ALMOST);
`else
  // Pass-through: valid moves go straight to the FIFO.
  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    wr_data = 4'h0;
    case (state_q)
      S_EMPTY: begin
        if (xfer) begin
          if (is_end) begin
            state_d = S_DONE;
          end else if (is_move) begin
            wr_req  = 1'b1;
            wr_data = i_move;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  assign ready_d = (count_d != CNT_FULL);
`endif

  // FIFO bookkeeping; a write into a full FIFO is dropped and flagged.
  always_comb begin
    wr_ok      = wr_req && (count_q != CNT_FULL);
    rd_ok      = i_q_pop && (count_q != '0);
    count_d    = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    overflow_d = overflow_q | (wr_req & ~wr_ok);
  end

  // Control registers.
  always_ff @(posedge i_clk_12m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      seq_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (i_clear) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      seq_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q    <= count_d;
      ready_q    <= ready_d;
      seq_done_q <= (state_d == S_DONE);
      overflow_q <= overflow_d;
    end
  end

  // Storage array, no reset needed: occupancy guards every read.
  always_ff @(posedge i_clk_12m) begin
    if (wr_ok && !i_clear) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign o_move_ready = ready_q;
  assign o_q_valid    = (count_q != '0);
  assign o_q_move     = mem_q[rd_ptr_q];
  assign o_count      = count_q;
  assign o_seq_done   = seq_done_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_move_queue_builder.sv
// Scoreboard bench for move_queue_builder: stimulus pushes expected FIFO
// entries, a negedge monitor compares the FIFO head on every pop.
module tb_move_queue_builder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

`ifdef MQ_MERGE_EN
  localparam int T2_CNT    = 1;
  localparam int F2_READY  = 0;
  localparam int FILL_PUSH = 255;
  localparam int FILL_RDY0 = 0;
  localparam logic [3:0] PP_EXP = 4'h2;
`else
  localparam int T2_CNT    = 3;
  localparam int F2_READY  = 1;
  localparam int FILL_PUSH = 256;
  localparam int FILL_RDY0 = 0;
  localparam logic [3:0] PP_EXP = 4'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          mv_valid = 1'b0;
  logic [3:0]    mv = 4'h0;
  logic          pop = 1'b0;
  logic          ready;
  logic          q_valid;
  logic [3:0]    q_move;
  logic [AW:0]   count;
  logic          seq_done;
  logic          overflow;

  int            total = 0;
  int            bad = 0;
  logic [3:0]    exp_q[$];

  move_queue_builder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk_12m   (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_move_valid(mv_valid),
    .i_move      (mv),
    .o_move_ready(ready),
    .o_q_valid   (q_valid),
    .o_q_move    (q_move),
    .i_q_pop     (pop),
    .o_count     (count),
    .o_seq_done  (seq_done),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted pop must match the oldest expected entry.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && q_valid && pop) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL q_move: got unexpected entry %h, required none", q_move);
        end else begin
          e = exp_q.pop_front();
          if (q_move !== e) begin
            bad++;
            $display("FAIL q_move: got %h required %h", q_move, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic send(input logic [3:0] m);
    int n;
    n = 0;
    mv_valid = 1'b1;
    mv = m;
    while (!ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: move %h never accepted, ready=%0d required 1", m, ready);
    end else begin
      @(posedge clk); #1;
    end
    mv_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    pop = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    pop = 1'b0;
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_count"}, int'(count), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_ready0", int'(ready), 0);
    chk("clear_done", int'(seq_done), 0);
    @(posedge clk); #1;
    chk("clear_ready1", int'(ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values and the one-cycle ready hold-off.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_qvalid", int'(q_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_done", int'(seq_done), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready0", int'(ready), 0);
    @(posedge clk); #1;
    chk("rel_ready1", int'(ready), 1);

    // W-CW, G-CW, end -> {0x0, 0x2}; moves after end are dropped.
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h2);
    send(4'h0); send(4'h2); send(4'hF);
    chk("t1_done", int'(seq_done), 1);
    chk("t1_count", int'(count), 2);
    send(4'h4);
    @(posedge clk); #1;
    chk("t1_drop_after_end", int'(count), 2);
    drain("t1");
    do_clear();

    // R-CW, R-CCW, B-CW, end: the R pair cancels when merging.
`ifdef MQ_MERGE_EN
    exp_q.push_back(4'h6);
`else
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h6);
`endif
    send(4'h4); send(4'h5); send(4'h6); send(4'hF);
    chk("t2_count", int'(count), T2_CNT);
    chk("t2_done", int'(seq_done), 1);
    drain("t2");
    do_clear();

    // O-CW, O-CW, Y-CCW, end: half turn becomes two CW entries.
    exp_q.push_back(4'h8);
    exp_q.push_back(4'h8);
    exp_q.push_back(4'hB);
    send(4'h8); send(4'h8); send(4'hB);
    chk("t3_flush2_ready", int'(ready), F2_READY);
    send(4'hF);
    chk("t3_count", int'(count), 3);
    drain("t3");
    do_clear();

    // Pop on empty is ignored; invalid 0xD is dropped.
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    chk("t4_pop_empty_count", int'(count), 0);
    chk("t4_pop_empty_valid", int'(q_valid), 0);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h3);
    send(4'h1); send(4'hD); send(4'h3); send(4'hF);
    chk("t4_count", int'(count), 2);
    drain("t4");
    do_clear();

    // Fill to the ready threshold with alternating faces.
    for (int i = 0; i < FILL_PUSH; i++) begin
      exp_q.push_back((i % 2 == 1) ? 4'h2 : 4'h0);
    end
    for (int i = 0; i < 256; i++) begin
      send((i % 2 == 1) ? 4'h2 : 4'h0);
    end
    chk("fill_count", int'(count), FILL_PUSH);
    chk("fill_ready", int'(ready), FILL_RDY0);
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    chk("fill_pop_count", int'(count), FILL_PUSH - 1);
    chk("fill_pop_ready", int'(ready), 1);
    exp_q.push_back(PP_EXP);
    pop = 1'b1;
    send(4'h0);
    pop = 1'b0;
    chk("fill_pushpop_count", int'(count), FILL_PUSH - 1);
    chk("fill_ovf", int'(overflow), 0);
    drain("fill");
    do_clear();

    // Reset in the middle of a sequence drops everything pending.
    send(4'h8); send(4'h8); send(4'hB);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(q_valid), 0);
    chk("mid_rst_done", int'(seq_done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", int'(ready), 1);
    exp_q.push_back(4'h4);
    send(4'h4); send(4'hF);
    chk("mid_rst_after_count", int'(count), 1);
    drain("mid_rst");
    chk("end_ovf", int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
